// File: rtl/cap_edge_det.sv
// Rising-edge detector for a level strobe: registers the previous sample and
// flags the cycle where the strobe goes 0->1.
module cap_edge_det (
  input  logic clk,
  input  logic clr,
  input  logic strobe,
  output logic rise
);

  logic cap_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      cap_d <= 1'b0;
    end else begin
      cap_d <= strobe;
    end
  end

  // Cleared history means a strobe already high right after reset counts as an edge.
  assign rise = strobe & ~cap_d;

endmodule

// File: rtl/count_capture_fifo.sv
// Snapshots the upstream counter on each capture edge into a small
// first-word-fall-through queue, with a sticky flag for dropped snapshots.
module count_capture_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] count_in,
  input  logic             cap,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level,
  output logic             ovf
);

  localparam logic [AW-1:0] PtrOne   = 1;
  localparam logic [AW:0]   LvlOne   = 1;
  localparam logic [AW:0]   LvlDepth = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_req, pop, push_ok, drop;

  cap_edge_det u_cap_edge_det (
    .clk    (clk),
    .clr    (clr),
    .strobe (cap),
    .rise   (push_req)
  );

  assign empty = (level == '0);
  assign full  = (level == LvlDepth);
  assign valid = ~empty;

  assign pop     = rd_en & valid;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PtrOne;
      if (pop)     rd_ptr <= rd_ptr + PtrOne;
      if (push_ok && !pop) begin
        level <= level + LvlOne;
      end else if (pop && !push_ok) begin
        level <= level - LvlOne;
      end
      if (drop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && push_ok) begin
      mem[wr_ptr] <= count_in;
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_count_capture_fifo.sv
// Self-checking bench for count_capture_fifo: directed scenarios plus random
// traffic compared cycle by cycle against a queue-based reference model.
module tb_count_capture_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] count_in = '0;
  logic       cap = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       valid, empty, full, ovf;
  logic [3:0] level;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  bit         m_prev = 1'b0;
  logic [7:0] cnt = '0;

  count_capture_fifo #(.WIDTH(8), .DEPTH(8), .AW(3)) dut (
    .clk      (clk),
    .clr      (clr),
    .count_in (count_in),
    .cap      (cap),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .valid    (valid),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit rise, popping;
    if (clr) begin
      q.delete();
      m_ovf  = 1'b0;
      m_prev = 1'b0;
    end else begin
      rise    = cap && !m_prev;
      popping = rd_en && (q.size() > 0);
      if (popping) void'(q.pop_front());
      if (rise) begin
        if (q.size() < DEPTH) q.push_back(count_in);
        else m_ovf = 1'b1;
      end
      m_prev = cap;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] exp_data;
    exp_data = (q.size() > 0) ? q[0] : 8'h00;
    check({tag, ".level"}, 32'(level), 32'(q.size()));
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".valid"}, 32'(valid), 32'(q.size() != 0));
    check({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
    check({tag, ".data"},  32'(rd_data), 32'(exp_data));
    check({tag, ".ovf"},   32'(ovf), 32'(m_ovf));
  endtask

  // Apply one cycle of inputs, advance the clock, then compare after the edge.
  task automatic step(input string tag, input bit c_clr, input bit c_cap, input bit c_rd,
                      input logic [7:0] val);
    clr      = c_clr;
    cap      = c_cap;
    rd_en    = c_rd;
    count_in = val;
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    step("rst", 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #1;
    // Reset with cap held high, then first capture on release
    step("rst_cap", 1'b1, 1'b1, 1'b0, 8'h11);
    step("rst_cap", 1'b1, 1'b1, 1'b0, 8'h12);
    step("first", 1'b0, 1'b1, 1'b0, 8'h13);
    check("first_val", 32'(rd_data), 32'h13);
    for (int i = 0; i < 3; i++) step("held", 1'b0, 1'b1, 1'b0, 8'h20 + 8'(i));
    check("first_lvl", 32'(level), 32'd1);

    // Held vs pulsed cap from a running counter
    do_reset();
    for (int i = 0; i < 5; i++) begin step("hold5", 1'b0, 1'b1, 1'b0, cnt); cnt++; end
    step("pulse", 1'b0, 1'b0, 1'b0, cnt); cnt++;
    step("pulse", 1'b0, 1'b1, 1'b0, cnt); cnt++;
    step("pulse", 1'b0, 1'b0, 1'b0, cnt); cnt++;
    step("pulse", 1'b0, 1'b1, 1'b0, cnt); cnt++;
    step("pulse", 1'b0, 1'b0, 1'b0, cnt); cnt++;
    check("pulse_lvl", 32'(level), 32'd3);
    for (int i = 0; i < 4; i++) step("pulse_drain", 1'b0, 1'b0, 1'b1, cnt);

    // Fill and overflow
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step("fill", 1'b0, 1'b1, 1'b0, 8'(10 * i));
      step("fill", 1'b0, 1'b0, 1'b0, 8'h00);
      if (i == 8) check("fill_full8", 32'(full), 32'd1);
    end
    check("fill_ovf", 32'(ovf), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", 32'(rd_data), 32'(10 * i));
      step("drain", 1'b0, 1'b0, 1'b1, 8'h00);
    end
    step("drain_more", 1'b0, 1'b1, 1'b1, 8'h55);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step("pp_fill", 1'b0, 1'b1, 1'b0, 8'(i));
      step("pp_fill", 1'b0, 1'b0, 1'b0, 8'h00);
    end
    step("pp_both", 1'b0, 1'b1, 1'b1, 8'd99);
    check("pp_lvl", 32'(level), 32'd8);
    check("pp_ovf", 32'(ovf), 32'd0);
    check("pp_head", 32'(rd_data), 32'd2);
    for (int i = 0; i < 8; i++) step("pp_drain", 1'b0, 1'b0, 1'b1, 8'h00);

    // Underflow then push/pop pairs across the pointer wrap
    do_reset();
    for (int i = 0; i < 3; i++) step("underflow", 1'b0, 1'b0, 1'b1, 8'hAA);
    for (int i = 0; i < 12; i++) begin
      step("wrap_push", 1'b0, 1'b1, 1'b0, 8'hF0 + 8'(i));
      check("wrap_val", 32'(rd_data), 32'(8'hF0 + 8'(i)));
      step("wrap_pop", 1'b0, 1'b0, 1'b1, 8'h00);
    end

    // Reset mid-operation: 5 entries with ovf set
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step("mid_fill", 1'b0, 1'b1, 1'b0, 8'h40 + 8'(i));
      step("mid_fill", 1'b0, 1'b0, 1'b0, 8'h00);
    end
    for (int i = 0; i < 3; i++) step("mid_pop", 1'b0, 1'b0, 1'b1, 8'h00);
    check("mid_lvl5", 32'(level), 32'd5);
    step("mid_clr", 1'b1, 1'b1, 1'b1, 8'h77);
    check("mid_ovf0", 32'(ovf), 32'd0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step("rand", ($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
